mem_copy_dma: RTL and testbench

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

---
 rtl/mem_copy_dma.sv | 93 +++++++++
 tb/tb_mem_copy_dma.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
// Word-by-word memory-to-memory copy engine. It reads src+i, then writes the
// captured word to dst+i, and repeats until len words have been moved.
module mem_copy_dma #(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words,
  output logic [31:0]      adr,
  output logic [31:0]      data,
  output logic             memread,
  output logic             memwrite,
  input  logic [31:0]      memout
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t           state, state_nx;
  logic [31:0]      src_r, dst_r, buf_r;
  logic [LEN_W-1:0] len_r, idx, words_r;
  logic             last;

  // idx never exceeds len-1, so idx+1 always fits in LEN_W bits.
  assign last  = (LEN_W'(idx + 1'b1) == len_r);
  assign words = words_r;

  // NOTE: every register in the clocked block uses <=, so all of them see
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      src_r   <= '0;
      dst_r   <= '0;
      len_r   <= '0;
      idx     <= '0;
      words_r <= '0;
      buf_r   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          src_r   <= src;
          dst_r   <= dst;
          len_r   <= len;
          idx     <= '0;
          words_r <= '0;
        end
        READ:  buf_r <= memout;
        WRITE: begin
          idx     <= idx + 1'b1;
          words_r <= words_r + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state, so an async reset drops memwrite
  // before the commit edge of an in-flight write.
  always_comb begin
    // NOTE: defaults first keep every output assigned on every path (no latches).
    state_nx = state;
    adr      = '0;
    data     = '0;
    memread  = 1'b0;
    memwrite = 1'b0;
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      IDLE: if (start) state_nx = (len == '0) ? DONE : READ;
      READ: begin
        adr      = src_r + 32'(idx);
        memread  = 1'b1;
        state_nx = WRITE;
      end
      WRITE: begin
        adr      = dst_r + 32'(idx);
        data     = buf_r;
        memwrite = 1'b1;
        state_nx = last ? DONE : READ;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: a behavioural memory responder plus a
// write scoreboard fed by a sequential reference copy on a shadow memory.
module tb_mem_copy_dma;
  localparam int LEN_W = 12;
  localparam int MEM_W = 14;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [31:0]      src, dst;
  logic [LEN_W-1:0] len;
  logic             busy, done, memread, memwrite;
  logic [LEN_W-1:0] words;
  logic [31:0]      adr, data, memout;

  mem_copy_dma #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .words(words), .adr(adr), .data(data),
    .memread(memread), .memwrite(memwrite), .memout(memout)
  );

  always #5 clk = ~clk;

  logic [31:0] mem    [0:(1<<MEM_W)-1];
  logic [31:0] shadow [0:(1<<MEM_W)-1];

  assign memout = mem[adr[MEM_W-1:0]];
  always @(posedge clk) if (memwrite) mem[adr[MEM_W-1:0]] <= data;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_q[$];
  wr_t         e;
  logic [31:0] rd_log[$];
  int checks = 0;
  int errors = 0;

  // Monitor: scoreboard every write, log every read address, police idle bus.
  always @(negedge clk) begin
    checks++;
    if (memread && memwrite) begin
      errors++;
      $display("FAIL strobe_excl: memread=1 memwrite=1, required not both");
    end
    if (memread) rd_log.push_back(adr);
    if (memwrite) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: adr=%h data=%h, required no write", adr, data);
      end else begin
        e = exp_q.pop_front();
        if (adr !== e.a || data !== e.d) begin
          errors++;
          $display("FAIL write_sb: adr=%h data=%h, required adr=%h data=%h", adr, data, e.a, e.d);
        end
      end
    end else if (!memread && (adr !== 32'h0 || data !== 32'h0)) begin
      errors++;
      $display("FAIL idle_bus: adr=%h data=%h, required 0/0", adr, data);
    end
  end

  task automatic load(input logic [31:0] a, input logic [31:0] v);
    mem[a[MEM_W-1:0]]    = v;
    shadow[a[MEM_W-1:0]] = v;
  endtask

  // Reference: strictly sequential forward copy on the shadow memory.
  task automatic model(input logic [31:0] s, input logic [31:0] d, input int l);
    logic [31:0] a, b, w;
    for (int k = 0; k < l; k++) begin
      a = s + 32'(k);
      b = d + 32'(k);
      w = shadow[a[MEM_W-1:0]];
      exp_q.push_back('{b, w});
      shadow[b[MEM_W-1:0]] = w;
    end
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int l,
                          input int inject, output int done_cyc, output int done_cnt,
                          output int busy_cnt);
    int budget;
    budget   = 2 * l + 6;
    done_cyc = 0;
    done_cnt = 0;
    busy_cnt = 0;
    rd_log.delete();
    @(negedge clk);
    src = s; dst = d; len = LEN_W'(l); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    src = 32'hDEAD_BEEF; dst = 32'h1234_5678; len = LEN_W'(7);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == inject) begin
        start = 1'b1; src = 32'd5; dst = 32'd6; len = LEN_W'(1);
      end else start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
    end
    start = 1'b0;
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles, required one", budget);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d writes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < (1 << MEM_W); k++) begin
      mem[k] = 32'h0; shadow[k] = 32'h0;
    end
    start = 1'b0; src = '0; dst = '0; len = '0;
    rst = 1'b1;
    #3;
    checks++;
    if ({busy, done, memread, memwrite} !== 4'b0 || words !== '0 || adr !== 32'h0 || data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b rd=%b wr=%b words=%0d adr=%h, required all 0",
               busy, done, memread, memwrite, words, adr);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int dc, dn, bc;
    int src_vals[10] = '{10, 8, 7, 6, 3, 9, 5, 4, 1, 12};
    for (int k = 0; k < 10; k++) load(32'd1000 + 32'(k), 32'(src_vals[k]));
    model(32'd1000, 32'd1500, 10);
    run_copy(32'd1000, 32'd1500, 10, 0, dc, dn, bc);
    check_int("basic_done_cycle", dc, 21);
    check_int("basic_done_count", dn, 1);
    check_int("basic_busy_cycles", bc, 21);
    check_int("basic_words", int'(words), 10);
    for (int k = 0; k < 10; k++) check_int("basic_mem", int'(mem[1500 + k]), src_vals[k]);
    check_sb_empty("basic");
  endtask

  task automatic test_len0;
    int dc, dn, bc;
    run_copy(32'd5, 32'd6, 0, 0, dc, dn, bc);
    check_int("len0_done_cycle", dc, 1);
    check_int("len0_busy_cycles", bc, 1);
    check_int("len0_reads", rd_log.size(), 0);
    check_int("len0_words", int'(words), 0);
    check_int("len0_mem6", int'(mem[6]), 0);
  endtask

  task automatic test_overlap;
    int dc, dn, bc;
    int fwd[4] = '{1, 1, 1, 1};
    int bwd[4] = '{2, 3, 4, 4};
    for (int k = 0; k < 4; k++) load(32'd100 + 32'(k), 32'(k + 1));
    model(32'd100, 32'd101, 3);
    run_copy(32'd100, 32'd101, 3, 0, dc, dn, bc);
    for (int k = 0; k < 4; k++) check_int("overlap_up", int'(mem[100 + k]), fwd[k]);
    for (int k = 0; k < 4; k++) load(32'd100 + 32'(k), 32'(k + 1));
    model(32'd101, 32'd100, 3);
    run_copy(32'd101, 32'd100, 3, 0, dc, dn, bc);
    for (int k = 0; k < 4; k++) check_int("overlap_down", int'(mem[100 + k]), bwd[k]);
    check_sb_empty("overlap");
  endtask

  task automatic test_wrap;
    int dc, dn, bc;
    load(32'hFFFF_FFFF, 32'hA5A5_0001);
    load(32'h0000_0000, 32'h5A5A_0002);
    model(32'hFFFF_FFFF, 32'd200, 2);
    run_copy(32'hFFFF_FFFF, 32'd200, 2, 0, dc, dn, bc);
    check_int("wrap_reads", rd_log.size(), 2);
    checks++;
    if (rd_log.size() == 2 && (rd_log[0] !== 32'hFFFF_FFFF || rd_log[1] !== 32'h0)) begin
      errors++;
      $display("FAIL wrap_adr: got %h,%h, required ffffffff,00000000", rd_log[0], rd_log[1]);
    end
    check_int("wrap_done_cycle", dc, 5);
    check_sb_empty("wrap");
  endtask

  task automatic test_reset_mid;
    int dc, dn, bc;
    for (int k = 0; k < 10; k++) begin
      load(32'd300 + 32'(k), 32'd50 + 32'(k));
      load(32'd600 + 32'(k), 32'd99);
    end
    model(32'd300, 32'd600, 3);
    @(negedge clk);
    src = 32'd300; dst = 32'd600; len = LEN_W'(10); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (memwrite !== 1'b1 || adr !== 32'd603) begin
      errors++;
      $display("FAIL rstmid_prewrite: memwrite=%b adr=%0d, required 1/603", memwrite, adr);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (memwrite !== 1'b0 || busy !== 1'b0 || words !== '0) begin
      errors++;
      $display("FAIL rstmid_abort: memwrite=%b busy=%b words=%0d, required 0/0/0", memwrite, busy, words);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_int("rstmid_no_done", int'(done), 0);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) check_int("rstmid_copied", int'(mem[600 + k]), 50 + k);
    check_int("rstmid_word3", int'(mem[603]), 99);
    check_sb_empty("rstmid");
    model(32'd300, 32'd700, 2);
    run_copy(32'd300, 32'd700, 2, 0, dc, dn, bc);
    check_int("postrst_done_cycle", dc, 5);
    check_int("postrst_words", int'(words), 2);
    check_sb_empty("postrst");
  endtask

  task automatic test_start_busy;
    int dc, dn, bc;
    for (int k = 0; k < 5; k++) load(32'd400 + 32'(k), 32'h100 + 32'(k));
    model(32'd400, 32'd800, 5);
    run_copy(32'd400, 32'd800, 5, 4, dc, dn, bc);
    check_int("busystart_done_cycle", dc, 11);
    check_int("busystart_done_count", dn, 1);
    check_int("busystart_words", int'(words), 5);
    check_sb_empty("busystart");
  endtask

  task automatic test_back_to_back;
    int dc, dn, bc;
    for (int k = 0; k < 3; k++) load(32'd450 + 32'(k), 32'h200 + 32'(k));
    model(32'd450, 32'd850, 3);
    run_copy(32'd450, 32'd850, 3, 7, dc, dn, bc);
    check_int("donestart_done_count", dn, 1);
    check_int("donestart_busy_cycles", bc, 7);
    check_int("donestart_words_hold", int'(words), 3);
    check_sb_empty("donestart");
  endtask

  task automatic test_max_len;
    int dc, dn, bc, bad;
    int n;
    n = (1 << LEN_W) - 1;
    for (int k = 0; k < n; k++) load(32'd4096 + 32'(k), 32'(k * 3 + 1));
    model(32'd4096, 32'd8192, n);
    run_copy(32'd4096, 32'd8192, n, 0, dc, dn, bc);
    check_int("maxlen_done_cycle", dc, 2 * n + 1);
    check_int("maxlen_words", int'(words), n);
    bad = 0;
    for (int k = 0; k < n; k++) if (mem[8192 + k] !== 32'(k * 3 + 1)) bad++;
    check_int("maxlen_mem_mismatches", bad, 0);
    check_sb_empty("maxlen");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_len0;
    test_overlap;
    test_wrap;
    test_reset_mid;
    test_start_busy;
    test_back_to_back;
    test_max_len;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
